// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types, constants and address checking for the memory responder
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam int LAT_CNT_W = 4;

    // Flags a byte address that is not word aligned or that has any bit set
    // above the word-index field. The address is passed zero-extended to 64 bits
    // so one function serves every data width up to 64.
    function automatic logic is_err(
        input logic [63:0] a,
        input int unsigned nbits,
        input int unsigned idx_w
    );
        logic bad;
        bad = (a[1:0] != 2'b00);
        for (int unsigned i = 2; i < 64; i++) begin
            if ((i >= idx_w + 2) && (i < nbits) && a[i]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word register file with one synchronous write port and a combinational read port
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [NBITS-1:0]         i_wdata,
    output logic [NBITS-1:0]         o_rdata
);

    logic [NBITS-1:0] r_mem [DEPTH];

    // Storage: cleared on reset, written one word per cycle when enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read port shares the index with the write port; the caller registers the result
    always_comb begin
        o_rdata = r_mem[i_idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding memory responder with fixed response latency
module dmem_responder
    import mem_resp_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             proc_req,
    input  logic [NBITS-1:0] addr,
    input  logic [NBITS-1:0] wdata,
    input  logic             wen,
    output logic             mem_rdy,
    output logic             valid,
    output logic [NBITS-1:0] rdata,
    output logic             err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    resp_state_t          r_state;
    resp_state_t          w_state_nxt;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic [LAT_CNT_W-1:0] w_cnt_nxt;

    logic [NBITS-1:0]     r_addr;
    logic [NBITS-1:0]     r_wdata;
    logic                 r_wen;
    logic [NBITS-1:0]     r_rdata;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_enter_resp;
    logic [NBITS-1:0]     w_src_addr;
    logic [NBITS-1:0]     w_src_wdata;
    logic                 w_src_wen;
    logic                 w_src_err;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_we;
    logic [NBITS-1:0]     w_rd_word;

    // Next-state, counter and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        mem_rdy      = 1'b0;
        valid        = 1'b0;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                mem_rdy = 1'b1;
                valid   = (r_state == RESP);
                if (proc_req) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = LAT_LOAD;
                    if (LATENCY > 1) begin
                        w_state_nxt = BUSY;
                    end else begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // With single-cycle latency the array is accessed on the acceptance edge itself,
    // so the live inputs are used instead of the not-yet-loaded request registers
    always_comb begin
        w_src_addr  = w_accept ? addr  : r_addr;
        w_src_wdata = w_accept ? wdata : r_wdata;
        w_src_wen   = w_accept ? wen   : r_wen;
        w_src_err   = is_err(64'(w_src_addr), NBITS, IDX_W);
        w_idx       = w_src_addr[IDX_W+1:2];
        w_we        = w_enter_resp && w_src_wen && !w_src_err;
    end

    mem_array #(
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (w_src_wdata),
        .o_rdata (w_rd_word)
    );

    // State, counter, request capture and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_wen   <= wen;
            end
            if (w_enter_resp) begin
                r_err <= w_src_err;
                if (w_src_err) begin
                    r_rdata <= '0;
                end else if (w_src_wen) begin
                    r_rdata <= w_src_wdata;
                end else begin
                    r_rdata <= w_rd_word;
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        proc_req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        mem_rdy;
    logic        valid;
    logic [31:0] rdata;
    logic        err;

    logic        proc_req1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        wen1;
    logic        mem_rdy1;
    logic        valid1;
    logic [31:0] rdata1;
    logic        err1;

    int checks;
    int failures;

    dmem_responder #(.NBITS(32), .DEPTH(64), .LATENCY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .proc_req (proc_req),
        .addr     (addr),
        .wdata    (wdata),
        .wen      (wen),
        .mem_rdy  (mem_rdy),
        .valid    (valid),
        .rdata    (rdata),
        .err      (err)
    );

    dmem_responder #(.NBITS(32), .DEPTH(64), .LATENCY(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .proc_req (proc_req1),
        .addr     (addr1),
        .wdata    (wdata1),
        .wen      (wen1),
        .mem_rdy  (mem_rdy1),
        .valid    (valid1),
        .rdata    (rdata1),
        .err      (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One LATENCY=2 transaction from idle: accept, one busy cycle, one response cycle.
    // Inputs are scrambled after acceptance to prove they are captured.
    task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        chk({tag, ".rdy"}, {31'b0, mem_rdy}, 32'd1);
        proc_req = 1'b1;
        addr     = a;
        wdata    = d;
        wen      = w;
        @(negedge clk);
        proc_req = 1'b0;
        addr     = ~a;
        wdata    = ~d;
        wen      = ~w;
        chk({tag, ".busy_valid"}, {31'b0, valid}, 32'd0);
        chk({tag, ".busy_rdy"}, {31'b0, mem_rdy}, 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, {31'b0, valid}, 32'd1);
        chk({tag, ".rdata"}, rdata, exp_rd);
        chk({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        proc_req  = 1'b0;
        addr      = '0;
        wdata     = '0;
        wen       = 1'b0;
        proc_req1 = 1'b0;
        addr1     = '0;
        wdata1    = '0;
        wen1      = 1'b0;

        // 1. reset values
        repeat (3) @(negedge clk);
        chk("rst.rdy", {31'b0, mem_rdy}, 32'd1);
        chk("rst.valid", {31'b0, valid}, 32'd0);
        chk("rst.err", {31'b0, err}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst.rdy", {31'b0, mem_rdy}, 32'd1);
        chk("post_rst.valid", {31'b0, valid}, 32'd0);
        xact("rd10", 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);

        // 2. write then read
        xact("wr08", 32'h08, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        chk("wr08.one_cycle", {31'b0, valid}, 32'd0);
        xact("rd08", 32'h08, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);

        // 3. back-to-back writes with proc_req held high
        @(negedge clk);
        proc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr  = 32'(4 * i);
            wdata = 32'(i + 1);
            wen   = 1'b1;
            @(negedge clk);
            chk("b2b.busy_valid", {31'b0, valid}, 32'd0);
            chk("b2b.busy_rdy", {31'b0, mem_rdy}, 32'd0);
            if (i == 2) proc_req = 1'b0;
            @(negedge clk);
            chk("b2b.valid", {31'b0, valid}, 32'd1);
            chk("b2b.rdy", {31'b0, mem_rdy}, 32'd1);
            chk("b2b.rdata", rdata, 32'(i + 1));
        end
        @(negedge clk);
        chk("b2b.end_valid", {31'b0, valid}, 32'd0);
        xact("rb0", 32'h0, 32'h0, 1'b0, 32'd1, 1'b0);
        xact("rb4", 32'h4, 32'h0, 1'b0, 32'd2, 1'b0);
        xact("rb8", 32'h8, 32'h0, 1'b0, 32'd3, 1'b0);

        // 4. errors
        xact("mis102", 32'h102, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("mis102.hold_valid", {31'b0, valid}, 32'd0);
        chk("mis102.hold_err", {31'b0, err}, 32'd1);
        xact("oor100", 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b1);
        xact("rd0_after_oor", 32'h0, 32'h0, 1'b0, 32'd1, 1'b0);

        // 5. reset in the middle of a write
        @(negedge clk);
        proc_req = 1'b1;
        addr     = 32'h20;
        wdata    = 32'h1234;
        wen      = 1'b1;
        @(negedge clk);
        proc_req = 1'b0;
        rst      = 1'b0;
        #1;
        chk("midrst.valid", {31'b0, valid}, 32'd0);
        chk("midrst.rdy", {31'b0, mem_rdy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst.no_valid", {31'b0, valid}, 32'd0);
            chk("midrst.rdy_after", {31'b0, mem_rdy}, 32'd1);
        end
        xact("midrst.rd20", 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
        xact("midrst.rd08", 32'h08, 32'h0, 1'b0, 32'h0, 1'b0);

        // 6a. requests toggled while busy are ignored
        @(negedge clk);
        proc_req = 1'b1;
        addr     = 32'h0;
        wen      = 1'b0;
        @(negedge clk);
        addr     = 32'h4;
        wdata    = 32'h55;
        wen      = 1'b1;
        chk("ign.busy_rdy", {31'b0, mem_rdy}, 32'd0);
        @(negedge clk);
        proc_req = 1'b0;
        chk("ign.valid", {31'b0, valid}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("ign.no_extra_valid", {31'b0, valid}, 32'd0);
        end
        xact("ign.rd4", 32'h4, 32'h0, 1'b0, 32'h0, 1'b0);

        // 6b. LATENCY=1 instance
        @(negedge clk);
        chk("l1.rdy", {31'b0, mem_rdy1}, 32'd1);
        proc_req1 = 1'b1;
        addr1     = 32'h0C;
        wdata1    = 32'hA5A5_5A5A;
        wen1      = 1'b1;
        @(negedge clk);
        proc_req1 = 1'b0;
        wdata1    = 32'h0;
        wen1      = 1'b0;
        chk("l1.wr_valid", {31'b0, valid1}, 32'd1);
        chk("l1.wr_rdata", rdata1, 32'hA5A5_5A5A);
        chk("l1.wr_rdy", {31'b0, mem_rdy1}, 32'd1);
        @(negedge clk);
        chk("l1.one_cycle", {31'b0, valid1}, 32'd0);
        proc_req1 = 1'b1;
        @(negedge clk);
        addr1 = 32'h3;
        chk("l1.rd_valid", {31'b0, valid1}, 32'd1);
        chk("l1.rd_rdata", rdata1, 32'hA5A5_5A5A);
        chk("l1.rd_err", {31'b0, err1}, 32'd0);
        @(negedge clk);
        proc_req1 = 1'b0;
        chk("l1.b2b_valid", {31'b0, valid1}, 32'd1);
        chk("l1.b2b_err", {31'b0, err1}, 32'd1);
        chk("l1.b2b_rdata", rdata1, 32'h0);
        @(negedge clk);
        chk("l1.end_valid", {31'b0, valid1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
